// File: rtl/header_assembler_pkg.sv
// Constants shared by the receive framer, the miner and the UART transmitter.
package header_assembler_pkg;

  localparam int HEADER_BYTES_DEF = 80;
  localparam int HEADER_BITS      = 640;
  localparam int UART_TIMEOUT_DEF = 5_000_000;
  localparam int FRAME_CNT_W      = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } asm_state_t;

endpackage

// File: rtl/header_assembler_if.sv
// Byte stream in, published block header and status out; no backpressure on rx.
interface header_assembler_if;
  import header_assembler_pkg::*;

  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [HEADER_BITS-1:0] block_header;
  logic                   header_ready;
  logic                   busy;
  logic                   timeout_err;
  logic [FRAME_CNT_W-1:0] frame_bytes;
  logic [31:0]            byte_count;

  modport master (
    output rx_data, rx_valid,
    input  block_header, header_ready, busy, timeout_err, frame_bytes, byte_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output block_header, header_ready, busy, timeout_err, frame_bytes, byte_count
  );

endinterface

// File: rtl/idle_timer.sv
// Down-counter reloaded by clear; expired once CYCLES-1 enabled cycles follow a clear.
// Holds at zero, so expired stays high until the next clear.
module idle_timer #(
  parameter int CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(CYCLES - 1);
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/header_assembler.sv
// Packs a serial byte stream into a header and publishes it one cycle after the last byte.
// Accepts a byte every cycle it is offered; stalled partial frames are dropped on timeout.
module header_assembler
  import header_assembler_pkg::*;
#(
  parameter int HEADER_BYTES   = HEADER_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT_DEF
) (
  input logic              clock,
  input logic              reset,
  header_assembler_if.slave bus
);

  localparam logic [FRAME_CNT_W-1:0] LAST_BYTE = FRAME_CNT_W'(HEADER_BYTES - 1);

  asm_state_t             state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [HEADER_BITS-1:0] shift_q, hold_q, shift_next;
  logic [31:0]            byte_count_q;
  logic                   ready_q, tout_q;
  logic                   publish, discard, timer_en, expired;

  assign shift_next = {shift_q[HEADER_BITS-9:0], bus.rx_data};

  idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (bus.rx_valid),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    publish  = 1'b0;
    discard  = 1'b0;
    timer_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          frame_d = FRAME_CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        // An arriving byte always beats the timeout in the same cycle.
        if (bus.rx_valid) begin
          if (frame_q == LAST_BYTE) begin
            publish = 1'b1;
            frame_d = '0;
            state_d = IDLE;
          end else begin
            frame_d = frame_q + FRAME_CNT_W'(1);
          end
        end else begin
          timer_en = 1'b1;
          if (expired) begin
            discard = 1'b1;
            frame_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_q      <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      byte_count_q <= '0;
      ready_q      <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      frame_q <= frame_d;
      ready_q <= publish;
      tout_q  <= discard;
      if (bus.rx_valid) begin
        shift_q      <= shift_next;
        byte_count_q <= byte_count_q + 32'd1;
      end else if (discard) begin
        shift_q <= '0;
      end
      if (publish) hold_q <= shift_next;
    end
  end

  assign bus.block_header = hold_q;
  assign bus.header_ready = ready_q;
  assign bus.busy         = (state_q == RECV);
  assign bus.timeout_err  = tout_q;
  assign bus.frame_bytes  = frame_q;
  assign bus.byte_count   = byte_count_q;

endmodule
